// File: rtl/fpnew_result_queue.sv
// Result FIFO behind the FPNew wrapper: buffers result/status/tag, accrues sticky fflags, supports flush.
// Optional combinational empty-queue bypass enabled by defining FPNEW_RESQ_BYPASS_EN.
module fpnew_result_queue #(
    parameter int FLEN      = 64,
    parameter int TAG_WIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FLEN-1:0]              result_i,
    input  logic [4:0]                   status_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [FLEN-1:0]              result_o,
    output logic [4:0]                   status_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    input  logic                         flush_i,
    input  logic                         fflags_clr_i,
    output logic [4:0]                   fflags_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH-1);

    logic [FLEN-1:0]      res_mem_q [DEPTH];
    logic [4:0]           sts_mem_q [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fflags_q, fflags_d;

    logic empty_w, bypass_w, pop_w, mem_pop_w, push_w;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + PW'(1);
    endfunction

    assign empty_w    = (count_q == '0);
    assign in_ready_o = (count_q < DEPTH_C);

`ifdef FPNEW_RESQ_BYPASS_EN
    assign bypass_w = empty_w && in_valid_i && !flush_i;
`else
    assign bypass_w = 1'b0;
`endif

    // Outputs are forced to zero while empty so unreset storage never leaks out
    always_comb begin
        out_valid_o = 1'b0;
        result_o    = '0;
        status_o    = '0;
        tag_o       = '0;
        if (!empty_w) begin
            out_valid_o = 1'b1;
            result_o    = res_mem_q[rd_ptr_q];
            status_o    = sts_mem_q[rd_ptr_q];
            tag_o       = tag_mem_q[rd_ptr_q];
        end else if (bypass_w) begin
            out_valid_o = 1'b1;
            result_o    = result_i;
            status_o    = status_i;
            tag_o       = tag_i;
        end
    end

    assign pop_w     = out_valid_o && out_ready_i;
    assign mem_pop_w = pop_w && !empty_w;
    // A bypassed entry taken by writeback in the same cycle is never stored
    assign push_w    = in_valid_i && in_ready_o && !flush_i && !(bypass_w && out_ready_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w)    wr_ptr_d = next_ptr(wr_ptr_q);
            if (mem_pop_w) rd_ptr_d = next_ptr(rd_ptr_q);
            if (push_w && !mem_pop_w)      count_d = count_q + CW'(1);
            else if (!push_w && mem_pop_w) count_d = count_q - CW'(1);
        end
    end

    // Clear takes effect before the retiring entry accrues
    assign fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (pop_w ? status_o : 5'b0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            res_mem_q[wr_ptr_q] <= result_i;
            sts_mem_q[wr_ptr_q] <= status_i;
            tag_mem_q[wr_ptr_q] <= tag_i;
        end
    end

    assign fflags_o = fflags_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_fpnew_result_queue.sv
// Randomized and directed bench for fpnew_result_queue against a queue-based reference model.
module tb_fpnew_result_queue;
    localparam int FLEN = 64;
    localparam int TW   = 5;
    localparam int DEPTH = 4;
    localparam int CW   = $clog2(DEPTH+1);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [FLEN-1:0] result_i;
    logic [4:0]      status_i;
    logic [TW-1:0]   tag_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [FLEN-1:0] result_o;
    logic [4:0]      status_o;
    logic [TW-1:0]   tag_o;
    logic            flush_i;
    logic            fflags_clr_i;
    logic [4:0]      fflags_o;
    logic [CW-1:0]   count_o;

    fpnew_result_queue #(.FLEN(FLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
        .flush_i(flush_i), .fflags_clr_i(fflags_clr_i),
        .fflags_o(fflags_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [FLEN-1:0] r;
        logic [4:0]      s;
        logic [TW-1:0]   t;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] m_ff;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check outputs, advance the model across the next posedge
    task automatic cycle(input logic iv, input logic [FLEN-1:0] r, input logic [4:0] s,
                         input logic [TW-1:0] t, input logic ordy, input logic fl, input logic clr);
        logic byp, ev, pop, acc;
        ent_t h;
        @(negedge clk_i);
        in_valid_i = iv; result_i = r; status_i = s; tag_i = t;
        out_ready_i = ordy; flush_i = fl; fflags_clr_i = clr;
        #1;
        byp = 1'b0;
`ifdef FPNEW_RESQ_BYPASS_EN
        byp = (mq.size() == 0) && iv && !fl;
`endif
        h = '{r: '0, s: '0, t: '0};
        ev = 1'b0;
        if (mq.size() != 0) begin
            h = mq[0]; ev = 1'b1;
        end else if (byp) begin
            h = '{r: r, s: s, t: t}; ev = 1'b1;
        end
        check_eq("in_ready",  64'(in_ready_o),  64'(mq.size() < DEPTH));
        check_eq("out_valid", 64'(out_valid_o), 64'(ev));
        check_eq("result",    result_o,         h.r);
        check_eq("status",    64'(status_o),    64'(h.s));
        check_eq("tag",       64'(tag_o),       64'(h.t));
        check_eq("count",     64'(count_o),     64'(mq.size()));
        check_eq("fflags",    64'(fflags_o),    64'(m_ff));
        pop = ev && ordy;
        acc = iv && (mq.size() < DEPTH) && !fl && !(byp && ordy);
        m_ff = (clr ? 5'b0 : m_ff) | (pop ? h.s : 5'b0);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (acc) mq.push_back('{r: r, s: s, t: t});
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        in_valid_i = 0; result_i = '0; status_i = '0; tag_i = '0;
        out_ready_i = 0; flush_i = 0; fflags_clr_i = 0;
        m_ff = '0;
        #12;
        check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_count",     64'(count_o),     64'd0);
        check_eq("rst_fflags",    64'(fflags_o),    64'd0);
        check_eq("rst_result",    result_o,         64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single result with writeback ready
        cycle(1'b1, 64'h3FF0000000000000, 5'b00001, 5'd3, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_eq("t1_fflags", 64'(fflags_o), 64'd1);
        check_eq("t1_count",  64'(count_o),  64'd0);

        // Fill while stalled, reject a fifth, then drain in order
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 64'(i) + 64'h100, 5'b0, TW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h999, 5'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        check_eq("full_count", 64'(count_o),    64'd4);
        check_eq("full_ready", 64'(in_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
        end
        idle(1'b1);
        check_eq("drain_count", 64'(count_o), 64'd0);

        // Continuous streaming across pointer wrap
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 64'(i) << 8, 5'b0, TW'(10 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush with concurrent input and retiring head
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 64'h2000 + 64'(i), 5'b00010 << i, TW'(20 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h7777, 5'b10000, 5'd7, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        check_eq("flush_count",  64'(count_o),     64'd0);
        check_eq("flush_valid",  64'(out_valid_o), 64'd0);
        check_eq("flush_fflags", 64'(fflags_o),    64'b00010);

        // Clear and accrue in the same cycle
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'h1, 5'b10000, 5'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        cycle(1'b1, 64'h2, 5'b00100, 5'd2, 1'b0, 1'b0, 1'b0);
        check_eq("clr_pre", 64'(fflags_o), 64'b10000);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        check_eq("clr_accrue", 64'(fflags_o), 64'b00100);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 6, {$urandom, $urandom}, 5'($urandom), TW'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);

        // Asynchronous reset mid-burst
        cycle(1'b1, 64'hAAAA, 5'b11111, 5'd4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hBBBB, 5'b00001, 5'd5, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        @(negedge clk_i);
        in_valid_i = 0; out_ready_i = 0; flush_i = 0; fflags_clr_i = 0;
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_valid",  64'(out_valid_o), 64'd0);
        check_eq("arst_count",  64'(count_o),     64'd0);
        check_eq("arst_fflags", 64'(fflags_o),    64'd0);
        check_eq("arst_tag",    64'(tag_o),       64'd0);
        mq.delete();
        m_ff = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b1, 64'h55, 5'b01000, 5'd6, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
